// File: rtl/shift_pipe_pkg.sv
// Shared types and constants for the shift_pipe_stage wrapper.
// Optional rotate support is selected with the SHIFT_PIPE_ROTATE_EN macro.
package shift_pipe_pkg;

  localparam int DATA_WIDTH_C = 32;
  localparam int SHAMT_W      = 5;
  localparam int TAG_WIDTH_C  = 4;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // One request as held in stage 1.
  typedef struct packed {
    logic [DATA_WIDTH_C-1:0] d;
    logic [DATA_WIDTH_C-1:0] s;
    logic                    lnr;
    logic                    rot;
    logic [TAG_WIDTH_C-1:0]  tag;
  } s1_req_t;

endpackage

// File: rtl/shift32.sv
// SHIFT32: legacy 32-bit combinational logical barrel shifter.
// Any shift amount of 32 or more produces zero.
module SHIFT32 (
  input  logic [31:0] D,
  input  logic [31:0] S,
  input  logic        LNR,
  output logic [31:0] Y
);

  // Logical shift by S[4:0]; the upper bits of S force a zero result.
  always_comb begin
    Y = '0;
    if (S[31:5] == '0) begin
      Y = LNR ? (D << S[4:0]) : (D >> S[4:0]);
    end
  end

endmodule

// File: rtl/shift_flag_gen.sv
// Carry and zero flag generation for the shift pipe.
// With SHIFT_PIPE_ROTATE_EN defined, rotate requests use the rotate carry rule;
// otherwise rot is ignored and only the logical-shift carry exists.
module shift_flag_gen
  import shift_pipe_pkg::*;
(
  input  logic [DATA_WIDTH_C-1:0] d,
  input  logic [SHAMT_W-1:0]      n,
  input  logic                    s_hi_nz,
  input  logic                    lnr,
  input  logic                    rot,
  input  logic [DATA_WIDTH_C-1:0] y,
  output logic                    carry,
  output logic                    zero
);

  logic [SHAMT_W-1:0] left_idx;
  logic [SHAMT_W-1:0] right_idx;
  logic               log_carry;

  // 32-n wraps to the right 5-bit index for n in 1..31; n = 0 is masked below.
  assign left_idx  = SHAMT_W'(0) - n;
  assign right_idx = n - SHAMT_W'(1);

  // Last bit pushed out by a logical shift; nothing leaves for n = 0 or s >= 32.
  always_comb begin
    log_carry = 1'b0;
    if (!s_hi_nz && (n != '0)) begin
      if (lnr == DIR_RIGHT) begin
        log_carry = d[right_idx];
      end else begin
        log_carry = d[left_idx];
      end
    end
  end

`ifdef SHIFT_PIPE_ROTATE_EN
  // Rotates report the bit that wrapped around to the far end of the result.
  always_comb begin
    carry = log_carry;
    if (rot) begin
      carry = 1'b0;
      if (n != '0) begin
        carry = (lnr == DIR_LEFT) ? y[0] : y[DATA_WIDTH_C-1];
      end
    end
  end
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign carry      = log_carry;
`endif

  assign zero = (y == '0);

endmodule

// File: rtl/shift_pipe_stage.sv
// shift_pipe_stage: two-stage valid/ready pipeline around SHIFT32.
// Stage 1 registers the request, stage 2 registers result, flags and tag.
// SHIFT_PIPE_ROTATE_EN adds rotate support through a second SHIFT32 instance.
module shift_pipe_stage
  import shift_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_d,
  input  logic [DATA_WIDTH-1:0] in_s,
  input  logic                  in_lnr,
  input  logic                  in_rot,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic                  out_carry,
  output logic                  out_zero,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  if ((DATA_WIDTH != DATA_WIDTH_C) || (TAG_WIDTH != TAG_WIDTH_C)) begin : g_param_check
    $error("shift_pipe_stage supports only DATA_WIDTH=32 and TAG_WIDTH=4");
  end

  s1_req_t                 s1_req;
  logic                    s1_valid;
  logic                    s2_valid;
  logic                    s2_adv;
  logic                    in_fire;
  logic [DATA_WIDTH_C-1:0] shift_y;
  logic                    carry_nxt;
  logic                    zero_nxt;

  // Stage 2 can take new data when empty or being drained this cycle.
  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Stage 1: capture the request on accept, empty out when it moves on.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_req   <= '{d: in_d, s: in_s, lnr: in_lnr, rot: in_rot, tag: in_tag};
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

`ifdef SHIFT_PIPE_ROTATE_EN
  logic [DATA_WIDTH_C-1:0] main_s;
  logic [DATA_WIDTH_C-1:0] main_y;
  logic [DATA_WIDTH_C-1:0] wrap_s;
  logic [DATA_WIDTH_C-1:0] wrap_y;
  logic                    wrap_lnr;

  // A rotate is the main shift OR'd with the opposite shift by 32-n; for n = 0
  // the opposite shift is by 32 and contributes nothing, leaving d.
  assign main_s   = s1_req.rot ? DATA_WIDTH_C'(s1_req.s[SHAMT_W-1:0]) : s1_req.s;
  assign wrap_s   = DATA_WIDTH_C'(DATA_WIDTH_C) - DATA_WIDTH_C'(s1_req.s[SHAMT_W-1:0]);
  assign wrap_lnr = ~s1_req.lnr;

  SHIFT32 u_shift (
    .D   (s1_req.d),
    .S   (main_s),
    .LNR (s1_req.lnr),
    .Y   (main_y)
  );

  SHIFT32 u_wrap (
    .D   (s1_req.d),
    .S   (wrap_s),
    .LNR (wrap_lnr),
    .Y   (wrap_y)
  );

  assign shift_y = s1_req.rot ? (main_y | wrap_y) : main_y;
`else
  SHIFT32 u_shift (
    .D   (s1_req.d),
    .S   (s1_req.s),
    .LNR (s1_req.lnr),
    .Y   (shift_y)
  );
`endif

  shift_flag_gen u_flags (
    .d       (s1_req.d),
    .n       (s1_req.s[SHAMT_W-1:0]),
    .s_hi_nz (|s1_req.s[DATA_WIDTH_C-1:SHAMT_W]),
    .lnr     (s1_req.lnr),
    .rot     (s1_req.rot),
    .y       (shift_y),
    .carry   (carry_nxt),
    .zero    (zero_nxt)
  );

  // Stage 2: load result and flags whenever the output slot is free or draining.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_valid  <= 1'b0;
      out_y     <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (s2_adv) begin
      s2_valid  <= s1_valid;
      out_y     <= shift_y;
      out_carry <= carry_nxt;
      out_zero  <= zero_nxt;
      out_tag   <= s1_req.tag;
    end
  end

endmodule

// File: tb/tb_shift_pipe_stage.sv
// Self-checking bench for shift_pipe_stage with a scoreboard queue.
// Compile with +define+SHIFT_PIPE_ROTATE_EN to exercise rotate support.
module tb_shift_pipe_stage;

  typedef struct packed {
    logic [31:0] y;
    logic        c;
    logic        z;
    logic [3:0]  tag;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_d;
  logic [31:0] in_s;
  logic        in_lnr;
  logic        in_rot;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_carry;
  logic        out_zero;
  logic [3:0]  out_tag;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  shift_pipe_stage #(.DATA_WIDTH(32), .TAG_WIDTH(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d      (in_d),
    .in_s      (in_s),
    .in_lnr    (in_lnr),
    .in_rot    (in_rot),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  always #5 CLK = ~CLK;

  // Reference: wide shifts so the carry is simply the bit just past the result.
  function automatic exp_t model(input logic [31:0] d, input logic [31:0] s,
                                 input logic lnr, input logic rot, input logic [3:0] tag);
    exp_t        e;
    logic [63:0] w;
    logic [31:0] r;
    int          n;
    n     = int'(s[4:0]);
    e.tag = tag;
    e.y   = '0;
    e.c   = 1'b0;
`ifdef SHIFT_PIPE_ROTATE_EN
    if (rot) begin
      r = d;
      for (int i = 0; i < n; i++) r = lnr ? {r[30:0], r[31]} : {r[0], r[31:1]};
      e.y = r;
      e.c = (n == 0) ? 1'b0 : (lnr ? r[0] : r[31]);
      e.z = (r == 32'h0);
      return e;
    end
`endif
    if (s[31:5] == 27'h0) begin
      if (lnr) begin
        w   = {32'h0, d} << n;
        e.y = w[31:0];
        e.c = w[32];
      end else begin
        w   = {d, 32'h0} >> n;
        e.y = w[63:32];
        e.c = w[31];
      end
    end
    e.z = (e.y == 32'h0);
    return e;
  endfunction

  task automatic test_reset();
    RST = 1'b0; in_valid = 1'b0; in_d = '0; in_s = '0; in_lnr = 1'b0;
    in_rot = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_y !== 32'h0) begin errors++; $display("FAIL reset_out_y: got %h want 0", out_y); end
    checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry: got %b want 0", out_carry); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge CLK);
    #1;
  endtask

  // Single request into an empty pipe; checks 2-cycle latency and the result.
  task automatic test_vector(input string name, input logic [31:0] d, input logic [31:0] s,
                             input logic lnr, input logic rot, input logic [3:0] tag,
                             input logic [31:0] ey, input logic ec, input logic ez);
    exp_t e;
    sb.delete();
    sb.push_back('{y: ey, c: ec, z: ez, tag: tag});
    in_d = d; in_s = s; in_lnr = lnr; in_rot = rot; in_tag = tag;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept: in_ready got %b want 1", name, in_ready); end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    @(negedge CLK);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early: out_valid got %b want 0", name, out_valid); end
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_latency: out_valid got %b want 1", name, out_valid);
    end else begin
      e = sb.pop_front();
      checks++; if (out_y !== e.y) begin errors++; $display("FAIL %s_y: got %h want %h", name, out_y, e.y); end
      checks++; if (out_carry !== e.c) begin errors++; $display("FAIL %s_carry: got %b want %b", name, out_carry, e.c); end
      checks++; if (out_zero !== e.z) begin errors++; $display("FAIL %s_zero: got %b want %b", name, out_zero, e.z); end
      checks++; if (out_tag !== e.tag) begin errors++; $display("FAIL %s_tag: got %h want %h", name, out_tag, e.tag); end
    end
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_dup: out_valid got %b want 0", name, out_valid); end
    @(posedge CLK);
    #1;
    sb.delete();
  endtask

  // Streams n requests; stall_mode uses tags 0.. and a 3-cycle out_ready gap,
  // otherwise data, tags and out_ready are random.
  task automatic test_back_to_back(input int n, input bit stall_mode);
    exp_t e;
    int   sent, got, cyc;
    bit   accepted;
    logic exp_rdy;
    sent = 0; got = 0; cyc = 0;
    sb.delete();
    while ((got < n) && (cyc < n * 10)) begin
      if (sent < n) begin
        if ((cyc == 0) || accepted) begin
          in_d   = $urandom;
          in_s   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 33));
          in_lnr = 1'($urandom_range(0, 1));
          in_rot = stall_mode ? 1'b0 : 1'($urandom_range(0, 1));
          in_tag = stall_mode ? 4'(sent) : 4'($urandom_range(0, 15));
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = stall_mode ? !((cyc >= 3) && (cyc <= 5)) : ($urandom_range(0, 2) != 0);
      accepted  = 1'b0;
      @(negedge CLK);
      exp_rdy = (sb.size() < 2) || out_ready;
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL stream_in_ready: cycle %0d got %b want %b", cyc, in_ready, exp_rdy); end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL stream_spurious: out_valid with tag %h, nothing expected", out_tag);
        end else begin
          e = sb[0];
          if ((out_y !== e.y) || (out_carry !== e.c) || (out_zero !== e.z) || (out_tag !== e.tag)) begin
            errors++;
            $display("FAIL stream_result: got y=%h c=%b z=%b tag=%h want y=%h c=%b z=%b tag=%h",
                     out_y, out_carry, out_zero, out_tag, e.y, e.c, e.z, e.tag);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_d, in_s, in_lnr, in_rot, in_tag));
        sent++;
        accepted = 1'b1;
      end
      @(posedge CLK);
      #1;
      cyc++;
    end
    checks++; if (got != n) begin errors++; $display("FAIL stream_timeout: received %0d want %0d", got, n); end
    in_valid = 1'b0; out_ready = 1'b1;
    sb.delete();
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_async_reset();
    sb.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_d = 32'hDEADBEEF; in_s = 32'd3; in_lnr = 1'b1; in_rot = 1'b0; in_tag = 4'h1;
    @(posedge CLK);
    #1;
    in_tag = 4'h2;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_inflight: out_valid got %b want 1", out_valid); end
    #2;
    RST = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_immediate: out_valid got %b want 0", out_valid); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL arst_tag: got %h want 0", out_tag); end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_ghost: cycle %0d out_valid got %b want 0", i, out_valid); end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_vector("right31", 32'hFFFFFFFF, 32'd31, 1'b0, 1'b0, 4'h3, 32'h00000001, 1'b1, 1'b0);
    test_vector("left1", 32'h80000001, 32'd1, 1'b1, 1'b0, 4'h4, 32'h00000002, 1'b1, 1'b0);
    test_vector("oor32", 32'hFFFFFFFF, 32'd32, 1'b1, 1'b0, 4'h5, 32'h00000000, 1'b0, 1'b1);
    test_vector("zero_amt", 32'h12345678, 32'd0, 1'b1, 1'b0, 4'h7, 32'h12345678, 1'b0, 1'b0);
    test_vector("hi_bits", 32'h12345678, 32'h00000100, 1'b0, 1'b0, 4'h8, 32'h00000000, 1'b0, 1'b1);
    test_vector("left31", 32'h00000003, 32'd31, 1'b1, 1'b0, 4'h9, 32'h80000000, 1'b1, 1'b0);
`ifdef SHIFT_PIPE_ROTATE_EN
    test_vector("rot_right4", 32'h80000001, 32'd4, 1'b0, 1'b1, 4'hA, 32'h18000000, 1'b0, 1'b0);
    test_vector("rot_left_hi", 32'h80000001, 32'h00000021, 1'b1, 1'b1, 4'hB, 32'h00000003, 1'b1, 1'b0);
    test_vector("rot_zero", 32'h80000001, 32'h00000040, 1'b0, 1'b1, 4'hC, 32'h80000001, 1'b0, 1'b0);
`else
    test_vector("rot_ignored", 32'h80000001, 32'd4, 1'b0, 1'b1, 4'hA, 32'h08000000, 1'b0, 1'b0);
`endif
    test_back_to_back(6, 1'b1);
    test_back_to_back(40, 1'b0);
    test_async_reset();
    test_vector("after_reset", 32'h0000F000, 32'd12, 1'b0, 1'b0, 4'hE, 32'h0000000F, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
